// File: rtl/mux_design_pkg.sv
// Shared definitions for mux_design: Q1 function-select encoding, the
// default debounce length and the Q1 logic-function helper.
package mux_design_pkg;

  // Q1 function select encoding
  typedef enum logic [1:0] {
    SEL_AND  = 2'd0,
    SEL_OR   = 2'd1,
    SEL_XOR  = 2'd2,
    SEL_NOTA = 2'd3
  } sel_e;

  // Default number of cycles btn_s must disagree before btn_clean follows
  localparam int DEBOUNCE_DEFAULT = 4;

  // Q1 logic function of the two data operands
  function automatic logic logic_fn(input sel_e sel, input logic a, input logic b);
    logic res;
    res = 1'b0;
    case (sel)
      SEL_AND:  res = a & b;
      SEL_OR:   res = a | b;
      SEL_XOR:  res = a ^ b;
      SEL_NOTA: res = ~a;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mux_design_btn_debounce.sv
// btn_debounce: two-flop synchronizer for the asynchronous push-button,
// followed by a consecutive-disagreement debouncer.
// Build option: define MUX_DESIGN_DEBOUNCE_EN to include the debouncer;
// without it btn_clean is the synchronizer output directly and
// DEBOUNCE_CYCLES has no effect.
module btn_debounce
  import mux_design_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_clean
);

  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer bringing btn into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef MUX_DESIGN_DEBOUNCE_EN
  // Counter sized to hold DEBOUNCE_CYCLES without wrapping
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The edge on which the counter would reach DEBOUNCE_CYCLES is the
  // edge where the count is currently one below it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;

  // Count consecutive disagreeing cycles; adopt btn_s once the run completes
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      clean_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debouncer state; reset discards any partial count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign btn_clean = clean_q;
`else
  assign btn_clean = sync2_q;
`endif

endmodule

// File: rtl/mux_design.sv
// mux_design: registered 4-function logic unit (Q1) and a registered 2:1
// mux (Q2) whose source is chosen by a synchronized, debounced button.
// Build option: MUX_DESIGN_DEBOUNCE_EN enables the button debouncer.
module mux_design
  import mux_design_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  input  logic [1:0] S,
  input  logic       btn,
  output logic       Q1,
  output logic       Q2
);

  logic btn_clean;
  logic q1_d;
  logic q1_q;
  logic q2_d;
  logic q2_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .btn_clean(btn_clean)
  );

  // Next values: selected logic function and button-selected mux source
  always_comb begin
    q1_d = logic_fn(sel_e'(S), A, B);
    if (btn_clean) begin
      q2_d = B;
    end else begin
      q2_d = A;
    end
  end

  // Output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign Q1 = q1_q;
  assign Q2 = q2_q;

endmodule

// File: tb/tb_mux_design.sv
// Self-checking bench for mux_design with a behavioural reference model.
// Honours MUX_DESIGN_DEBOUNCE_EN in the same way as the design.
module tb_mux_design;

  localparam int D = 4;
`ifdef MUX_DESIGN_DEBOUNCE_EN
  localparam int LAT = 2 + D;
  localparam bit DEB_EN = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit DEB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic [1:0] S = 2'd0;
  logic       btn = 1'b0;
  logic       Q1;
  logic       Q2;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic btn_hist[$];   // btn samples of the last two edges (oldest first)
  logic clean_m;
  int   run_m;
  logic q1_m;
  logic q2_m;

  mux_design #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .S(S), .btn(btn), .Q1(Q1), .Q2(Q2)
  );

  always #5 clk = ~clk;

  function automatic logic ref_fn(input logic [1:0] s, input logic a, input logic b);
    case (s)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic model_reset();
    btn_hist = '{1'b0, 1'b0};
    clean_m = 1'b0;
    run_m = 0;
    q1_m = 1'b0;
    q2_m = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_edge();
    logic s_val;
    if (rst) begin
      model_reset();
    end else begin
      s_val = btn_hist[0];  // btn as sampled two edges ago = synchronized level
      q1_m = ref_fn(S, A, B);
      q2_m = (DEB_EN ? clean_m : s_val) ? B : A;
      if (s_val != clean_m) begin
        run_m++;
        if (run_m == D) begin
          clean_m = s_val;
          run_m = 0;
        end
      end else begin
        run_m = 0;
      end
      void'(btn_hist.pop_front());
      btn_hist.push_back(btn);
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: update model, wait for the edge, compare both outputs
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_q1"}, Q1, q1_m);
    check({tag, "_q2"}, Q2, q2_m);
  endtask

  // btn rises at edge k (i = 0); Q2 must move from A (=0) to B (=1) at k+LAT
  task automatic press_latency(input string tag);
    A = 1'b0; B = 1'b1; S = 2'd0; btn = 1'b0;
    for (int i = 0; i < D + 3; i++) step({tag, "_settle"});
    btn = 1'b1;
    for (int i = 0; i <= LAT + 2; i++) begin
      step({tag, "_model"});
      check({tag, "_lat"}, Q2, (i >= LAT) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    int hold_left;
    model_reset();

    // Reset held: sweep every input, outputs stay 0
    for (int v = 0; v < 32; v++) begin
      A = v[0]; B = v[1]; S = v[3:2]; btn = v[4];
      step("rst_hold");
      check("rst_hold_q1_zero", Q1, 1'b0);
      check("rst_hold_q2_zero", Q2, 1'b0);
    end
    btn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Truth table: every select for every operand pair
    for (int ab = 0; ab < 4; ab++) begin
      for (int s = 0; s < 4; s++) begin
        A = ab[0]; B = ab[1]; S = s[1:0];
        step("truth");
      end
    end
    A = 1'b0; B = 1'b1; S = 2'd2; step("xor_ex");
    check("xor_ex_const", Q1, 1'b1);
    A = 1'b0; S = 2'd3; step("nota_ex");
    check("nota_ex_const", Q1, 1'b1);

    // Debounced select latency
    press_latency("press");

    // Glitch shorter than the debounce length
    A = 1'b0; B = 1'b1; btn = 1'b0;
    for (int i = 0; i < D + 6; i++) step("glitch_pre");
    check("glitch_pre_q2", Q2, 1'b0);
    btn = 1'b1; step("glitch"); step("glitch");
    btn = 1'b0;
    for (int i = 0; i < D + 4; i++) begin
      step("glitch_post");
      if (DEB_EN) check("glitch_q2_low", Q2, 1'b0);
    end

    // Async reset between edges while both outputs are 1
    A = 1'b1; B = 1'b1; S = 2'd1;
    step("pre_rst"); step("pre_rst");
    check("pre_rst_q1_one", Q1, 1'b1);
    check("pre_rst_q2_one", Q2, 1'b1);
    btn = 1'b1; step("mid_debounce"); step("mid_debounce"); step("mid_debounce");
    btn = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_q1", Q1, 1'b0);
    check("async_rst_q2", Q2, 1'b0);
    #1 rst = 1'b0;
    press_latency("post_rst");

    // Randomized traffic: btn held for random lengths to mix glitches and presses
    hold_left = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold_left == 0) begin
        btn = $urandom_range(0, 1);
        hold_left = $urandom_range(1, 8);
      end
      hold_left--;
      A = $urandom_range(0, 1);
      B = $urandom_range(0, 1);
      S = 2'($urandom_range(0, 3));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
